// File: rtl/axi_cmd_arbiter_if.sv
// AXI4-Lite command channels plus the command-FIFO and completion signals of the arbiter.
// The slave modport is the arbiter's view; master is the driving side.
interface axi_cmd_arbiter_if #(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CMD_W  = 1 + ADDR_W + DATA_W + STRB_W;
    localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);

    logic              aw_valid;
    logic [ADDR_W-1:0] aw_addr;
    logic              aw_ready;
    logic              w_valid;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
    logic              w_ready;
    logic              ar_valid;
    logic [ADDR_W-1:0] ar_addr;
    logic              ar_ready;
    logic              fifo_full;
    logic              fifo_push;
    logic [CMD_W-1:0]  fifo_wdata;
    logic              cmd_done;
    logic [CNT_W-1:0]  outstanding;

    modport slave (
        input  aw_valid, aw_addr, w_valid, w_data, w_strb, ar_valid, ar_addr,
        input  fifo_full, cmd_done,
        output aw_ready, w_ready, ar_ready, fifo_push, fifo_wdata, outstanding
    );

    modport master (
        output aw_valid, aw_addr, w_valid, w_data, w_strb, ar_valid, ar_addr,
        output fifo_full, cmd_done,
        input  aw_ready, w_ready, ar_ready, fifo_push, fifo_wdata, outstanding
    );
endinterface

// File: rtl/axi_cmd_arbiter.sv
// Holds AXI4-Lite write (AW+W) and read (AR) requests and round-robin pushes them into the
// shared command FIFO, bounded by FIFO-full and an outstanding-command limit.
module axi_cmd_arbiter #(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input logic              clk,
    input logic              rst,
    axi_cmd_arbiter_if.slave bus
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    // Write-path state is exactly {aw_held, w_held}.
    typedef enum logic [1:0] {
        WrEmpty = 2'b00,
        WrData  = 2'b01,
        WrAddr  = 2'b10,
        WrBoth  = 2'b11
    } wr_state_e;

    wr_state_e         wr_state_q, wr_state_d;
    logic              ar_held_q, ar_held_d;
    logic              last_wr_q, last_wr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [ADDR_W-1:0] aw_addr_q;
    logic [ADDR_W-1:0] ar_addr_q;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;

    logic aw_hs, w_hs, ar_hs;
    logic wr_req, rd_req, can_issue, grant_wr, push;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q <= WrEmpty;
            ar_held_q  <= 1'b0;
            last_wr_q  <= 1'b1;
            cnt_q      <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            ar_held_q  <= ar_held_d;
            last_wr_q  <= last_wr_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_addr_q <= '0;
            ar_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (aw_hs) aw_addr_q <= bus.aw_addr;
            if (ar_hs) ar_addr_q <= bus.ar_addr;
            if (w_hs) begin
                w_data_q <= bus.w_data;
                w_strb_q <= bus.w_strb;
            end
        end
    end

    always_comb begin
        aw_hs     = bus.aw_valid && !wr_state_q[1];
        w_hs      = bus.w_valid && !wr_state_q[0];
        ar_hs     = bus.ar_valid && !ar_held_q;
        wr_req    = (wr_state_q == WrBoth);
        rd_req    = ar_held_q;
        can_issue = !bus.fifo_full && (cnt_q < CNT_MAX);
        // On contention the channel not granted last time wins.
        grant_wr  = wr_req && (!rd_req || !last_wr_q);
        push      = !rst && can_issue && (wr_req || rd_req);
    end

    always_comb begin
        wr_state_d = wr_state_q;
        unique case (wr_state_q)
            WrEmpty: begin
                if (aw_hs && w_hs) wr_state_d = WrBoth;
                else if (aw_hs)    wr_state_d = WrAddr;
                else if (w_hs)     wr_state_d = WrData;
            end
            WrAddr: if (w_hs)  wr_state_d = WrBoth;
            WrData: if (aw_hs) wr_state_d = WrBoth;
            WrBoth: if (push && grant_wr) wr_state_d = WrEmpty;
        endcase

        ar_held_d = ar_held_q;
        if (push && !grant_wr) ar_held_d = 1'b0;
        else if (ar_hs)        ar_held_d = 1'b1;

        last_wr_d = push ? grant_wr : last_wr_q;

        // Push and completion in the same cycle cancel; completion at zero is dropped.
        cnt_d = cnt_q;
        if (push && !bus.cmd_done)                     cnt_d = cnt_q + CNT_W'(1);
        else if (!push && bus.cmd_done && cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    end

    always_comb begin
        bus.aw_ready    = !wr_state_q[1];
        bus.w_ready     = !wr_state_q[0];
        bus.ar_ready    = !ar_held_q;
        bus.fifo_push   = push;
        bus.outstanding = cnt_q;
        bus.fifo_wdata  = '0;
        if (push) begin
            if (grant_wr) bus.fifo_wdata = {1'b1, aw_addr_q, w_data_q, w_strb_q};
            else          bus.fifo_wdata = {1'b0, ar_addr_q, {DATA_W{1'b0}}, {STRB_W{1'b0}}};
        end
    end
endmodule

// File: tb/tb_axi_cmd_arbiter.sv
// Directed vector table plus hand-written limit and async-reset sequences for
// axi_cmd_arbiter (32-bit address/data, limit of 4).
module tb_axi_cmd_arbiter;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MAXO   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_cmd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAXO)) bus ();

    axi_cmd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAXO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        aw_v, w_v, ar_v;
        logic [31:0] aw_a, w_d, ar_a;
        logic [3:0]  w_s;
        logic        full, done;
        logic        e_push;
        logic [68:0] e_wd;
        logic [2:0]  e_rdy;  // {aw_ready, w_ready, ar_ready}
        logic [2:0]  e_out;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;
    int   pushes;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [68:0] wr(input logic [31:0] a, input logic [31:0] d,
                                       input logic [3:0] s);
        return {1'b1, a, d, s};
    endfunction

    function automatic logic [68:0] rd(input logic [31:0] a);
        return {1'b0, a, 32'h0, 4'h0};
    endfunction

    function automatic vec_t mk(input logic [2:0] v, input logic [31:0] awa,
                                input logic [31:0] wd, input logic [3:0] ws,
                                input logic [31:0] ara, input logic [1:0] fd,
                                input logic ep, input logic [68:0] ewd,
                                input logic [2:0] erdy, input logic [2:0] eout);
        vec_t r;
        r.aw_v = v[2]; r.w_v = v[1]; r.ar_v = v[0];
        r.aw_a = awa; r.w_d = wd; r.w_s = ws; r.ar_a = ara;
        r.full = fd[1]; r.done = fd[0];
        r.e_push = ep; r.e_wd = ewd; r.e_rdy = erdy; r.e_out = eout;
        return r;
    endfunction

    task automatic drive_idle();
        bus.aw_valid = 1'b0; bus.aw_addr = '0;
        bus.w_valid = 1'b0; bus.w_data = '0; bus.w_strb = '0;
        bus.ar_valid = 1'b0; bus.ar_addr = '0;
        bus.fifo_full = 1'b0; bus.cmd_done = 1'b0;
    endtask

    initial begin
        // W before AW, then a single write push
        vecs.push_back(mk(3'b010, '0, 32'hA5A5A5A5, 4'hF, '0, 2'b00, 1'b0, '0, 3'b111, 3'd0));
        vecs.push_back(mk(3'b000, '0, '0, '0, '0, 2'b00, 1'b0, '0, 3'b101, 3'd0));
        vecs.push_back(mk(3'b100, 32'h10, '0, '0, '0, 2'b00, 1'b0, '0, 3'b101, 3'd0));
        vecs.push_back(mk(3'b000, '0, '0, '0, '0, 2'b00, 1'b1,
                          wr(32'h10, 32'hA5A5A5A5, 4'hF), 3'b001, 3'd0));
        vecs.push_back(mk(3'b000, '0, '0, '0, '0, 2'b01, 1'b0, '0, 3'b111, 3'd1));
        // Contention after a write grant: read first, then write, then alternate
        vecs.push_back(mk(3'b111, 32'h30, 32'h11223344, 4'h3, 32'h20, 2'b00, 1'b0, '0,
                          3'b111, 3'd0));
        vecs.push_back(mk(3'b000, '0, '0, '0, '0, 2'b00, 1'b1, rd(32'h20), 3'b000, 3'd0));
        vecs.push_back(mk(3'b001, '0, '0, '0, 32'h24, 2'b00, 1'b1,
                          wr(32'h30, 32'h11223344, 4'h3), 3'b001, 3'd1));
        vecs.push_back(mk(3'b110, 32'h34, 32'h55667788, 4'hC, '0, 2'b00, 1'b1, rd(32'h24),
                          3'b110, 3'd2));
        vecs.push_back(mk(3'b001, '0, '0, '0, 32'h28, 2'b01, 1'b1,
                          wr(32'h34, 32'h55667788, 4'hC), 3'b001, 3'd3));
        vecs.push_back(mk(3'b000, '0, '0, '0, '0, 2'b01, 1'b1, rd(32'h28), 3'b110, 3'd3));
        vecs.push_back(mk(3'b000, '0, '0, '0, '0, 2'b01, 1'b0, '0, 3'b111, 3'd3));
        vecs.push_back(mk(3'b000, '0, '0, '0, '0, 2'b01, 1'b0, '0, 3'b111, 3'd2));
        vecs.push_back(mk(3'b000, '0, '0, '0, '0, 2'b01, 1'b0, '0, 3'b111, 3'd1));
        // Read held under FIFO-full, pushed once full drops
        vecs.push_back(mk(3'b001, '0, '0, '0, 32'h40, 2'b10, 1'b0, '0, 3'b111, 3'd0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(3'b000, '0, '0, '0, '0, 2'b10, 1'b0, '0, 3'b110, 3'd0));
        vecs.push_back(mk(3'b000, '0, '0, '0, '0, 2'b00, 1'b1, rd(32'h40), 3'b110, 3'd0));
        vecs.push_back(mk(3'b000, '0, '0, '0, '0, 2'b01, 1'b0, '0, 3'b111, 3'd1));
        // Write held under FIFO-full
        vecs.push_back(mk(3'b110, 32'h50, 32'hDEADBEEF, 4'hF, '0, 2'b10, 1'b0, '0,
                          3'b111, 3'd0));
        vecs.push_back(mk(3'b000, '0, '0, '0, '0, 2'b10, 1'b0, '0, 3'b001, 3'd0));
        vecs.push_back(mk(3'b000, '0, '0, '0, '0, 2'b00, 1'b1,
                          wr(32'h50, 32'hDEADBEEF, 4'hF), 3'b001, 3'd0));
        vecs.push_back(mk(3'b000, '0, '0, '0, '0, 2'b01, 1'b0, '0, 3'b111, 3'd1));

        // Reset with every valid high
        rst = 1'b1;
        drive_idle();
        bus.aw_valid = 1'b1; bus.w_valid = 1'b1; bus.ar_valid = 1'b1;
        step();
        step();
        chk("rst ready", {bus.aw_ready, bus.w_ready, bus.ar_ready}, 3'b111);
        chk("rst push", bus.fifo_push, 1'b0);
        chk("rst wdata", bus.fifo_wdata, '0);
        chk("rst outstanding", bus.outstanding, '0);
        drive_idle();
        rst = 1'b0;
        step();

        foreach (vecs[i]) begin
            bus.aw_valid = vecs[i].aw_v; bus.aw_addr = vecs[i].aw_a;
            bus.w_valid = vecs[i].w_v; bus.w_data = vecs[i].w_d; bus.w_strb = vecs[i].w_s;
            bus.ar_valid = vecs[i].ar_v; bus.ar_addr = vecs[i].ar_a;
            bus.fifo_full = vecs[i].full; bus.cmd_done = vecs[i].done;
            #1;
            chk($sformatf("v%0d push", i), bus.fifo_push, vecs[i].e_push);
            chk($sformatf("v%0d wdata", i), bus.fifo_wdata, vecs[i].e_wd);
            chk($sformatf("v%0d ready", i), {bus.aw_ready, bus.w_ready, bus.ar_ready},
                vecs[i].e_rdy);
            chk($sformatf("v%0d outstanding", i), bus.outstanding, vecs[i].e_out);
            step();
        end

        // Outstanding limit: continuous reads, no completions
        drive_idle();
        bus.ar_valid = 1'b1;
        bus.ar_addr = 32'h60;
        pushes = 0;
        for (int c = 0; c < 14; c++) begin
            #1;
            if (bus.fifo_push) pushes++;
            step();
        end
        #1;
        chk("lim pushes", pushes, 4);
        chk("lim outstanding", bus.outstanding, 3'd4);
        chk("lim stalled push", bus.fifo_push, 1'b0);
        chk("lim ar_ready", bus.ar_ready, 1'b0);
        bus.cmd_done = 1'b1;
        step();
        #1;
        chk("lim 5th push", bus.fifo_push, 1'b1);
        chk("lim 5th wdata", bus.fifo_wdata, rd(32'h60));
        chk("lim after done", bus.outstanding, 3'd3);
        step();
        bus.cmd_done = 1'b0;
        bus.ar_valid = 1'b0;
        #1;
        chk("lim push+done", bus.outstanding, 3'd3);

        // Async reset with only AW held and three commands in flight
        step();
        bus.aw_valid = 1'b1;
        bus.aw_addr = 32'h70;
        step();
        bus.aw_valid = 1'b0;
        #1;
        chk("ar aw held", bus.aw_ready, 1'b0);
        chk("ar pre outstanding", bus.outstanding, 3'd3);
        rst = 1'b1;
        #1;
        chk("ar aw cleared", bus.aw_ready, 1'b1);
        chk("ar outstanding", bus.outstanding, 3'd0);
        chk("ar push", bus.fifo_push, 1'b0);
        rst = 1'b0;
        step();
        bus.w_valid = 1'b1;
        bus.w_data = 32'h12345678;
        bus.w_strb = 4'hF;
        step();
        bus.w_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("ar w only push c%0d", c), bus.fifo_push, 1'b0);
            chk($sformatf("ar w only ready c%0d", c), {bus.aw_ready, bus.w_ready}, 2'b10);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
